// File: rtl/ascon_ctrl_pkg.sv
// Shared types and helpers for the ASCON-128 AEAD control FSM.
package ascon_ctrl_pkg;

  // Highest round-constant index count of the ASCON permutation.
  localparam int NB_ROUNDS_MAX = 12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_WAIT_AD,
    ST_AD,
    ST_WAIT_DATA,
    ST_DATA,
    ST_FINAL,
    ST_TAG
  } ctrl_state_e;

  // First round-constant index of a permutation run of 'rounds' rounds.
  function automatic logic [3:0] round_start(input int rounds);
    return 4'(NB_ROUNDS_MAX - rounds);
  endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Loadable 4-bit round counter; raises last_round on the final constant index.
module ascon_round_counter
  import ascon_ctrl_pkg::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load,
  input  logic [3:0] start,
  input  logic       en,
  output logic [3:0] count,
  output logic       last_round
);

  // Load takes priority over increment so a new permutation can start on the
  // same edge that ends the previous one.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!resetb_i) begin
      count <= '0;
    end else if (load) begin
      count <= start;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign last_round = (count == 4'(NB_ROUNDS_MAX - 1));

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 AEAD controller: sequences load, p^a/p^b permutations, XOR
// injections and cipher/tag capture, with an internal block counter and a
// ready/valid handshake pacing block input. All outputs are registered.
module ascon_ctrl_fsm
  import ascon_ctrl_pkg::*;
#(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int NB_W     = 4
) (
  input  logic            clock_i,
  input  logic            resetb_i,
  input  logic            start_i,
  input  logic            decrypt_i,
  input  logic [NB_W-1:0] nb_ad_i,
  input  logic [NB_W-1:0] nb_data_i,
  input  logic            data_valid_i,
  output logic            data_ready_o,
  output logic            data_sel_o,
  output logic            en_reg_state_o,
  output logic [3:0]      round_o,
  output logic [NB_W-1:0] block_o,
  output logic            en_xor_data_o,
  output logic            en_xor_key_o,
  output logic            en_xor_key_end_o,
  output logic            en_xor_lsb_o,
  output logic            en_cipher_o,
  output logic            en_tag_o,
  output logic            cipher_valid_o,
  output logic            decrypt_o,
  output logic            busy_o,
  output logic            end_o
);

  localparam logic [3:0] START_A  = round_start(ROUNDS_A);
  localparam logic [3:0] START_B  = round_start(ROUNDS_B);
  localparam logic [3:0] LAST_IDX = 4'(NB_ROUNDS_MAX - 1);
  localparam logic [3:0] PENULT   = 4'(NB_ROUNDS_MAX - 2);

  ctrl_state_e     state, state_nxt;
  logic [NB_W-1:0] blk, blk_nxt;
  logic [NB_W-1:0] nb_ad, nb_data;
  logic            cnt_load, cnt_en, last_round, nxt_last, xfer, entering;
  logic [3:0]      cnt_start, round;

  assign xfer     = data_valid_i & data_ready_o;
  assign entering = (state_nxt != state);
  assign round_o  = round;
  assign block_o  = blk;

  ascon_round_counter u_round_cnt (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .load       (cnt_load),
    .start      (cnt_start),
    .en         (cnt_en),
    .count      (round),
    .last_round (last_round)
  );

  // Next state, block counter and round-counter control; the counter is
  // loaded on every state exit so it holds the right index on entry.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    blk_nxt   = blk;
    cnt_load  = 1'b0;
    cnt_start = '0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        blk_nxt = '0;
        if (start_i) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ST_INIT;
        cnt_load  = 1'b1;
        cnt_start = START_A;
      end
      ST_INIT: begin
        if (last_round) begin
          cnt_load  = 1'b1;
          state_nxt = (nb_ad != '0) ? ST_WAIT_AD : ST_WAIT_DATA;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT_AD: begin
        if (xfer) begin
          state_nxt = ST_AD;
          cnt_load  = 1'b1;
          cnt_start = START_B;
        end
      end
      ST_AD: begin
        if (last_round) begin
          cnt_load = 1'b1;
          if (blk == nb_ad - NB_W'(1)) begin
            state_nxt = ST_WAIT_DATA;
            blk_nxt   = '0;
          end else begin
            state_nxt = ST_WAIT_AD;
            blk_nxt   = blk + NB_W'(1);
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT_DATA: begin
        if (xfer) begin
          cnt_load = 1'b1;
          if (blk == nb_data - NB_W'(1)) begin
            state_nxt = ST_FINAL;
            cnt_start = START_A;
          end else begin
            state_nxt = ST_DATA;
            cnt_start = START_B;
          end
        end
      end
      ST_DATA: begin
        if (last_round) begin
          cnt_load  = 1'b1;
          blk_nxt   = blk + NB_W'(1);
          state_nxt = ST_WAIT_DATA;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_FINAL: begin
        if (last_round) begin
          cnt_load  = 1'b1;
          state_nxt = ST_TAG;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_TAG: begin
        state_nxt = ST_IDLE;
        blk_nxt   = '0;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // The cycle about to start is the last round of its permutation.
    nxt_last = (cnt_load && cnt_start == LAST_IDX) || (cnt_en && round == PENULT);
  end

  // State, latched message parameters and registered outputs, the latter
  // decoded from the state being entered so they line up with it.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state            <= ST_IDLE;
      blk              <= '0;
      nb_ad            <= '0;
      nb_data          <= '0;
      decrypt_o        <= 1'b0;
      busy_o           <= 1'b0;
      data_ready_o     <= 1'b0;
      en_reg_state_o   <= 1'b0;
      data_sel_o       <= 1'b0;
      en_xor_data_o    <= 1'b0;
      en_cipher_o      <= 1'b0;
      en_xor_key_o     <= 1'b0;
      en_xor_key_end_o <= 1'b0;
      en_xor_lsb_o     <= 1'b0;
      en_tag_o         <= 1'b0;
      end_o            <= 1'b0;
      cipher_valid_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      blk   <= blk_nxt;
      if (state == ST_IDLE && start_i) begin
        nb_ad     <= nb_ad_i;
        nb_data   <= (nb_data_i == '0) ? NB_W'(1) : nb_data_i;
        decrypt_o <= decrypt_i;
      end
      busy_o           <= (state_nxt != ST_IDLE);
      data_ready_o     <= state_nxt inside {ST_WAIT_AD, ST_WAIT_DATA};
      en_reg_state_o   <= state_nxt inside {ST_LOAD, ST_INIT, ST_AD, ST_DATA, ST_FINAL};
      data_sel_o       <= state_nxt inside {ST_INIT, ST_AD, ST_DATA, ST_FINAL};
      en_xor_data_o    <= entering && (state_nxt inside {ST_AD, ST_DATA, ST_FINAL});
      en_cipher_o      <= entering && (state_nxt inside {ST_DATA, ST_FINAL});
      en_xor_key_o     <= entering && (state_nxt == ST_FINAL);
      en_xor_key_end_o <= nxt_last && (state_nxt inside {ST_INIT, ST_FINAL});
      en_xor_lsb_o     <= nxt_last &&
                          ((state_nxt == ST_INIT && nb_ad == '0) ||
                           (state_nxt == ST_AD && blk_nxt == nb_ad - NB_W'(1)));
      en_tag_o         <= (state_nxt == ST_TAG);
      end_o            <= (state_nxt == ST_TAG);
      cipher_valid_o   <= en_cipher_o;
    end
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Self-checking bench for ascon_ctrl_fsm: a timeline model pushes the expected
// per-cycle outputs of each message into a queue, popped as the DUT runs.
module tb_ascon_ctrl_fsm;

  typedef struct packed {
    logic ready, sel, en_reg, xdata, xkey, xkey_end, xlsb, cipher, tag, cv, done, busy, dec;
    logic [3:0] block;
  } obs_t;

  typedef struct packed {
    obs_t       o;
    logic       chk_round;
    logic [3:0] round;
  } exp_t;

  logic clock, resetb, start_a, start_b, decrypt, valid;
  logic [3:0] nb_ad, nb_data;

  logic rdy_a, sel_a, en_reg_a, xdata_a, xkey_a, xkey_end_a, xlsb_a, cipher_a, tag_a, cv_a, dec_a, busy_a, done_a;
  logic rdy_b, sel_b, en_reg_b, xdata_b, xkey_b, xkey_end_b, xlsb_b, cipher_b, tag_b, cv_b, dec_b, busy_b, done_b;
  logic [3:0] round_a, block_a, round_b, block_b;
  obs_t obs_a, obs_b;

  exp_t  exp_q[$];
  bit    cv_pend;
  int    n_cmp, n_bad;
  string tname;

  assign obs_a = {rdy_a, sel_a, en_reg_a, xdata_a, xkey_a, xkey_end_a, xlsb_a, cipher_a,
                  tag_a, cv_a, done_a, busy_a, dec_a, block_a};
  assign obs_b = {rdy_b, sel_b, en_reg_b, xdata_b, xkey_b, xkey_end_b, xlsb_b, cipher_b,
                  tag_b, cv_b, done_b, busy_b, dec_b, block_b};

  ascon_ctrl_fsm dut_a (
    .clock_i(clock), .resetb_i(resetb), .start_i(start_a), .decrypt_i(decrypt),
    .nb_ad_i(nb_ad), .nb_data_i(nb_data), .data_valid_i(valid), .data_ready_o(rdy_a),
    .data_sel_o(sel_a), .en_reg_state_o(en_reg_a), .round_o(round_a), .block_o(block_a),
    .en_xor_data_o(xdata_a), .en_xor_key_o(xkey_a), .en_xor_key_end_o(xkey_end_a),
    .en_xor_lsb_o(xlsb_a), .en_cipher_o(cipher_a), .en_tag_o(tag_a),
    .cipher_valid_o(cv_a), .decrypt_o(dec_a), .busy_o(busy_a), .end_o(done_a)
  );

  ascon_ctrl_fsm #(.ROUNDS_A(8), .ROUNDS_B(4), .NB_W(4)) dut_b (
    .clock_i(clock), .resetb_i(resetb), .start_i(start_b), .decrypt_i(decrypt),
    .nb_ad_i(nb_ad), .nb_data_i(nb_data), .data_valid_i(valid), .data_ready_o(rdy_b),
    .data_sel_o(sel_b), .en_reg_state_o(en_reg_b), .round_o(round_b), .block_o(block_b),
    .en_xor_data_o(xdata_b), .en_xor_key_o(xkey_b), .en_xor_key_end_o(xkey_end_b),
    .en_xor_lsb_o(xlsb_b), .en_cipher_o(cipher_b), .en_tag_o(tag_b),
    .cipher_valid_o(cv_b), .decrypt_o(dec_b), .busy_o(busy_b), .end_o(done_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t blank(input bit dec);
    exp_t e = '0;
    e.o.busy = 1'b1;
    e.o.dec  = dec;
    return e;
  endfunction

  // cipher_valid follows en_cipher by one cycle.
  task automatic push_e(input exp_t e);
    e.o.cv  = cv_pend;
    cv_pend = e.o.cipher;
    exp_q.push_back(e);
  endtask

  // Expected outputs for cycles 1..TAG+1 of one message; optional stall of
  // stall_n extra WAIT_DATA cycles before data block stall_blk.
  task automatic build_exp(input int ra, input int rb, input int nad, input int ndat,
                           input bit dec, input int stall_blk, input int stall_n,
                           output int vlo);
    exp_t e;
    int   nd;
    nd      = (ndat == 0) ? 1 : ndat;
    vlo     = 0;
    cv_pend = 1'b0;
    exp_q.delete();
    e = blank(dec); e.o.en_reg = 1'b1; push_e(e);
    for (int i = 0; i < ra; i++) begin
      e = blank(dec); e.o.sel = 1'b1; e.o.en_reg = 1'b1;
      e.chk_round = 1'b1; e.round = 4'(12 - ra + i);
      if (i == ra - 1) begin e.o.xkey_end = 1'b1; e.o.xlsb = (nad == 0); end
      push_e(e);
    end
    for (int b = 0; b < nad; b++) begin
      e = blank(dec); e.o.ready = 1'b1; e.o.block = 4'(b); push_e(e);
      for (int i = 0; i < rb; i++) begin
        e = blank(dec); e.o.sel = 1'b1; e.o.en_reg = 1'b1; e.o.block = 4'(b);
        e.chk_round = 1'b1; e.round = 4'(12 - rb + i);
        e.o.xdata = (i == 0);
        e.o.xlsb  = (i == rb - 1) && (b == nad - 1);
        push_e(e);
      end
    end
    for (int b = 0; b < nd; b++) begin
      int nr;
      nr = (b == nd - 1) ? ra : rb;
      if (b == stall_blk) vlo = exp_q.size() + 1;
      for (int w = 0; w < 1 + ((b == stall_blk) ? stall_n : 0); w++) begin
        e = blank(dec); e.o.ready = 1'b1; e.o.block = 4'(b); push_e(e);
      end
      for (int i = 0; i < nr; i++) begin
        e = blank(dec); e.o.sel = 1'b1; e.o.en_reg = 1'b1; e.o.block = 4'(b);
        e.chk_round = 1'b1; e.round = 4'(12 - nr + i);
        e.o.xdata  = (i == 0);
        e.o.cipher = (i == 0);
        if (b == nd - 1) begin
          e.o.xkey     = (i == 0);
          e.o.xkey_end = (i == nr - 1);
        end
        push_e(e);
      end
    end
    e = blank(dec); e.o.tag = 1'b1; e.o.done = 1'b1; e.o.block = 4'(nd - 1); push_e(e);
    e = '0; e.o.dec = dec; push_e(e);
  endtask

  // Starts a message at the current negedge, then scores one queue entry per
  // cycle; stop_at > 0 ends scoring early. Returns the cycle of en_tag.
  task automatic run_msg(input bit use_b, input bit dec, input int nad, input int ndat,
                         input int vlo, input int nlo, input int stop_at, input bit poke,
                         output int tag_cyc);
    exp_t       e;
    obs_t       ob;
    logic [3:0] rnd;
    int         rel;
    nb_ad   = 4'(nad);
    nb_data = 4'(ndat);
    decrypt = dec;
    valid   = 1'b1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    rel     = 0;
    tag_cyc = -1;
    while (exp_q.size() > 0 && (stop_at == 0 || rel < stop_at)) begin
      @(negedge clock);
      rel++;
      ob  = use_b ? obs_b : obs_a;
      rnd = use_b ? round_b : round_a;
      start_a = poke && !use_b && rel >= 20 && rel <= 22;
      start_b = poke &&  use_b && rel >= 20 && rel <= 22;
      if (rel == 5) decrypt = ~dec;
      valid = !(vlo > 0 && rel >= vlo && rel < vlo + nlo);
      e = exp_q.pop_front();
      n_cmp++;
      if (ob !== e.o) begin
        n_bad++;
        $display("FAIL %s cyc %0d outputs: got %b required %b", tname, rel, ob, e.o);
      end
      if (e.chk_round) begin
        n_cmp++;
        if (rnd !== e.round) begin
          n_bad++;
          $display("FAIL %s cyc %0d round_o: got %0d required %0d", tname, rel, rnd, e.round);
        end
      end
      if (ob.tag === 1'b1 && tag_cyc < 0) tag_cyc = rel;
    end
    exp_q.delete();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    tname  = "reset";
    resetb = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (obs_a !== '0)    begin n_bad++; $display("FAIL %s dut_a outputs: got %b required 0", tname, obs_a); end
    n_cmp++; if (obs_b !== '0)    begin n_bad++; $display("FAIL %s dut_b outputs: got %b required 0", tname, obs_b); end
    n_cmp++; if (round_a !== 4'd0) begin n_bad++; $display("FAIL %s dut_a round: got %0d required 0", tname, round_a); end
    n_cmp++; if (round_b !== 4'd0) begin n_bad++; $display("FAIL %s dut_b round: got %0d required 0", tname, round_b); end
    resetb = 1'b1;
    @(negedge clock);
    n_cmp++; if (obs_a !== '0) begin n_bad++; $display("FAIL %s idle after release: got %b required 0", tname, obs_a); end
  endtask

  task automatic test_basic();
    int vlo, tag;
    tname = "basic_ad1_data3";
    build_exp(12, 6, 1, 3, 1'b0, -1, 0, vlo);
    run_msg(1'b0, 1'b0, 1, 3, vlo, 0, 0, 1'b0, tag);
    n_cmp++; if (tag !== 48) begin n_bad++; $display("FAIL %s tag cycle: got %0d required 48", tname, tag); end
  endtask

  task automatic test_no_ad();
    int vlo, tag;
    tname = "no_ad_data1";
    build_exp(12, 6, 0, 1, 1'b0, -1, 0, vlo);
    run_msg(1'b0, 1'b0, 0, 1, vlo, 0, 0, 1'b0, tag);
    n_cmp++; if (tag !== 27) begin n_bad++; $display("FAIL %s tag cycle: got %0d required 27", tname, tag); end
  endtask

  task automatic test_zero_data();
    int vlo, tag;
    tname = "data0_as_1";
    build_exp(12, 6, 0, 0, 1'b0, -1, 0, vlo);
    run_msg(1'b0, 1'b0, 0, 0, vlo, 0, 0, 1'b0, tag);
    n_cmp++; if (tag !== 27) begin n_bad++; $display("FAIL %s tag cycle: got %0d required 27", tname, tag); end
  endtask

  task automatic test_short_rounds();
    int vlo, tag, want;
    tname = "ra8_rb4";
    want  = 1 + 8 + 2 * (1 + 4) + (2 - 1) * (1 + 4) + 1 + 8 + 1;
    build_exp(8, 4, 2, 2, 1'b0, -1, 0, vlo);
    run_msg(1'b1, 1'b0, 2, 2, vlo, 0, 0, 1'b0, tag);
    n_cmp++; if (tag !== want) begin n_bad++; $display("FAIL %s tag cycle: got %0d required %0d", tname, tag, want); end
  endtask

  task automatic test_stall();
    int vlo, tag;
    tname = "valid_stall";
    build_exp(12, 6, 1, 2, 1'b0, 1, 5, vlo);
    run_msg(1'b0, 1'b0, 1, 2, vlo, 5, 0, 1'b0, tag);
    n_cmp++; if (tag !== 46) begin n_bad++; $display("FAIL %s tag cycle: got %0d required 46", tname, tag); end
  endtask

  task automatic test_decrypt();
    int vlo, tag;
    tname = "decrypt_latch";
    build_exp(12, 6, 2, 2, 1'b1, -1, 0, vlo);
    run_msg(1'b0, 1'b1, 2, 2, vlo, 0, 0, 1'b1, tag);
    n_cmp++; if (tag !== 48) begin n_bad++; $display("FAIL %s tag cycle: got %0d required 48", tname, tag); end
    @(negedge clock);
    n_cmp++; if (dec_a !== 1'b1)  begin n_bad++; $display("FAIL %s decrypt_o in idle: got %b required 1", tname, dec_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL %s busy_o in idle: got %b required 0", tname, busy_a); end
  endtask

  task automatic test_back_to_back();
    int vlo, tag;
    tname = "b2b_first";
    build_exp(12, 6, 0, 2, 1'b0, -1, 0, vlo);
    run_msg(1'b0, 1'b0, 0, 2, vlo, 0, 0, 1'b0, tag);
    n_cmp++; if (tag !== 34) begin n_bad++; $display("FAIL %s tag cycle: got %0d required 34", tname, tag); end
    tname = "b2b_second";
    build_exp(12, 6, 1, 1, 1'b1, -1, 0, vlo);
    run_msg(1'b0, 1'b1, 1, 1, vlo, 0, 0, 1'b0, tag);
    n_cmp++; if (tag !== 34) begin n_bad++; $display("FAIL %s tag cycle: got %0d required 34", tname, tag); end
  endtask

  task automatic test_abort();
    int vlo, tag;
    tname = "abort";
    build_exp(12, 6, 1, 3, 1'b1, -1, 0, vlo);
    run_msg(1'b0, 1'b1, 1, 3, vlo, 0, 24, 1'b0, tag);
    #2 resetb = 1'b0;
    #1;
    n_cmp++; if (obs_a !== '0)    begin n_bad++; $display("FAIL %s async clear: got %b required 0", tname, obs_a); end
    n_cmp++; if (round_a !== 4'd0) begin n_bad++; $display("FAIL %s round clear: got %0d required 0", tname, round_a); end
    @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);
    n_cmp++; if (obs_a !== '0) begin n_bad++; $display("FAIL %s idle after abort: got %b required 0", tname, obs_a); end
    tname = "after_abort";
    build_exp(12, 6, 1, 3, 1'b0, -1, 0, vlo);
    run_msg(1'b0, 1'b0, 1, 3, vlo, 0, 0, 1'b0, tag);
    n_cmp++; if (tag !== 48) begin n_bad++; $display("FAIL %s tag cycle: got %0d required 48", tname, tag); end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    start_a = 1'b0;
    start_b = 1'b0;
    decrypt = 1'b0;
    valid   = 1'b0;
    nb_ad   = '0;
    nb_data = '0;
    resetb  = 1'b0;
    test_reset();
    test_basic();
    test_no_ad();
    test_zero_data();
    test_short_rounds();
    test_stall();
    test_decrypt();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ascon_ctrl_fsm.md
# ascon_ctrl_fsm

Parametrised control FSM for the ASCON-128 AEAD datapath. It drives state-register load/enable, the XOR injections, round-constant index, and cipher/tag capture. It also contains the round and block counters that the previous controller took from outside. Block counts and encrypt/decrypt mode are set per message at start, and an explicit ready/valid handshake paces block input.

## Interface
- ROUNDS_A, default 12: rounds of p^a (initialisation and finalisation); legal 1..12.
- ROUNDS_B, default 6: rounds of p^b (AD and data blocks); legal 1..12.
- NB_W, default 4: width of block-count inputs and block counter.
- clock_i  in  1  clock.
- resetb_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  start a message; sampled in IDLE only.
- decrypt_i  in  1  mode, latched at start (1 = decrypt).
- nb_ad_i  in  NB_W  number of associated-data blocks, latched at start; 0 is legal.
- nb_data_i  in  NB_W  number of plaintext/ciphertext blocks incl. padded last block, latched at start; 0 is treated as 1.
- data_valid_i  in  1  block present on data bus.
- data_ready_o  out  1  controller accepts a block this cycle.
- data_sel_o  out  1  0 = load IV||K||N into state mux, 1 = permutation output.
- en_reg_state_o  out  1  state register enable.
- round_o  out  4  round-constant index (12-ROUNDS+i).
- block_o  out  NB_W  current block index within phase.
- en_xor_data_o, en_xor_key_o, en_xor_key_end_o, en_xor_lsb_o  out  1 each  pre-permutation data XOR, pre-finalisation key XOR (capacity), post-permutation key XOR (LSBs), domain-separation XOR.
- en_cipher_o, en_tag_o  out  1 each  capture ciphertext / tag registers.
- cipher_valid_o  out  1  one-cycle pulse, cycle after en_cipher_o.
- decrypt_o  out  1  latched mode (datapath replaces rate with ciphertext).
- busy_o, end_o  out  1 each  message in progress / message done.

## Operation
- States: IDLE, LOAD, INIT, WAIT_AD, AD, WAIT_DATA, DATA, FINAL, TAG.
- IDLE: start_i=1 latches nb_ad, nb_data, decrypt, then goes to LOAD.
- LOAD (1 cycle): data_sel_o=0, en_reg_state_o=1.
- INIT (ROUNDS_A cycles): data_sel_o=1, en_reg_state_o=1, round_o from 12-ROUNDS_A to 11.
  - Last cycle: en_xor_key_end_o=1, plus en_xor_lsb_o=1 if nb_ad=0.
  - Exit to WAIT_AD if nb_ad>0, else WAIT_DATA.
- WAIT_AD / WAIT_DATA: data_ready_o=1.
  - Transfer on data_valid_i & data_ready_o, then enter AD / DATA.
  - From WAIT_DATA, the last block (block_o = nb_data-1) enters FINAL instead of DATA.
- AD (ROUNDS_B cycles): first cycle en_xor_data_o=1.
  - Last cycle increments block_o.
  - Last cycle of the last AD block: en_xor_lsb_o=1, clear block_o, go to WAIT_DATA.
- DATA (ROUNDS_B cycles): first cycle en_xor_data_o=1, en_cipher_o=1. Last cycle increments block_o.
- FINAL (ROUNDS_A cycles): first cycle en_xor_data_o, en_cipher_o, en_xor_key_o. Last cycle en_xor_key_end_o.
- TAG (1 cycle): en_tag_o=1, end_o=1, then IDLE.
- busy_o=1 in every state except IDLE.
- Counter widths: round counter 4 bits. Block counter wraps at 2^NB_W; nb_data = 2^NB_W cannot be expressed.

## Timing
- Reset: state IDLE, counters 0, decrypt_o=0, all outputs 0.
- Reset mid-message aborts immediately; no residual pulses.
- start_i outside IDLE is ignored. data_valid_i without data_ready_o is ignored (no buffering).
- Each WAIT state lasts at least 1 cycle; data_ready_o is never asserted in a round state.
- Latency with data_valid_i held high, start sampled at cycle 0: TAG at cycle 1 + ROUNDS_A + nb_ad·(1+ROUNDS_B) + (nb_data-1)·(1+ROUNDS_B) + 1 + ROUNDS_A + 1.
- cipher_valid_o fires exactly once per data block, including the final block.

## Structure
- Shared package ascon_ctrl_pkg holds:
  - state enum typedef;
  - constant NB_ROUNDS_MAX = 12;
  - function round_start(rounds) returning 12-rounds.
- One sub-module, ascon_round_counter: loadable 4-bit counter with start value, enable, and last-round flag. Instantiated once; the block counter stays inline.

## Test plan
- Defaults, nb_ad=1, nb_data=3, valid held high → LOAD at 1, INIT 2–13, AD 15–20, DATA 22–27 and 29–34, FINAL 36–47, TAG/end_o at 48; cipher_valid_o at 23, 30, 37.
- nb_ad=0, nb_data=1 → en_xor_lsb_o and en_xor_key_end_o both at cycle 13; WAIT_DATA at 14; FINAL 15–26; TAG at 27.
- ROUNDS_A=8, ROUNDS_B=4 → round_o sequences 4..11 and 8..11; TAG cycle matches the latency formula.
- data_valid_i low for 5 cycles in WAIT_DATA → data_ready_o held high, state frozen, all enables 0; resumes on the valid cycle.
- resetb_i low during DATA round 3 → all outputs 0 asynchronously; a following start_i runs a full clean message.
- decrypt_i=1 at start, toggled to 0 mid-message → decrypt_o stays 1 until the next start.
